// File: rtl/au_sched.sv
// au_sched: command sequencer and partial-sum accumulator for one PE arithmetic unit.
// Latches a layer command, drives the unit's mask/mode/numeric-type/reset/stall controls,
// accumulates signed per-beat partial sums into wide results and hands each result out
// over a rdy/ack port.
// Build option: define AU_SCHED_SAT_EN to saturate the accumulator instead of wrapping.
module au_sched #(
  parameter int DWd    = 16,
  parameter int AuODWd = 11,
  parameter int AccWd  = 20,
  parameter int LenWd  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [1:0]         i_cfg_mode,
  input  logic               i_cfg_inumt,
  input  logic               i_cfg_wnumt,
  input  logic [4:0]         i_cfg_lanes,
  input  logic [LenWd-1:0]   i_cfg_len,
  input  logic [LenWd-1:0]   i_cfg_nout,
  output logic [3*DWd-1:0]   o_au_mask,
  output logic [1:0]         o_au_mode,
  output logic               o_au_inumt,
  output logic               o_au_wnumt,
  output logic               o_au_reset,
  output logic               o_au_stall,
  input  logic [AuODWd-1:0]  i_au_sum,
  input  logic               i_au_sum_rdy,
  output logic               o_au_sum_ack,
  output logic [AccWd-1:0]   o_acc,
  output logic               o_acc_rdy,
  input  logic               i_acc_ack,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] MODE_M2 = 2'd2;
  localparam logic [1:0] MODE_M4 = 2'd3;

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic               inumt_q, wnumt_q;
  logic [3*DWd-1:0]   mask_q, mask_d;
  logic [LenWd-1:0]   len_q, nout_q, beat_q, grp_q;
  logic [AccWd-1:0]   acc_q, acc_next, out_q, sum_ext;
  logic               out_rdy_q;
  logic               blk, run_ok, beat_fire, last_beat, cmd_accept;
  int                 lane_max, lane_eff, run_w, run_off;

`ifdef AU_SCHED_SAT_EN
  localparam logic [AccWd-1:0] ACC_MAX = {1'b0, {(AccWd-1){1'b1}}};
  localparam logic [AccWd-1:0] ACC_MIN = {1'b1, {(AccWd-1){1'b0}}};
  logic [AccWd:0]     sum_wide;
  logic               sat_q, sat_hit;
`endif

  assign cmd_accept = (state_q == S_IDLE) && i_cfg_valid;
  assign last_beat  = (beat_q == len_q);
  // Hold the unit while the final beat of a group would overwrite an unconsumed result.
  assign blk        = last_beat && out_rdy_q && !i_acc_ack;
  assign run_ok     = (state_q == S_RUN) && !blk;
  assign beat_fire  = run_ok && i_au_sum_rdy;
  assign sum_ext    = {{(AccWd-AuODWd){i_au_sum[AuODWd-1]}}, i_au_sum};

  assign o_cfg_ready  = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_au_reset   = i_rst || (state_q == S_CLR);
  assign o_au_stall   = run_ok;
  assign o_au_sum_ack = run_ok;
  assign o_au_mask    = mask_q;
  assign o_au_mode    = mode_q;
  assign o_au_inumt   = inumt_q;
  assign o_au_wnumt   = wnumt_q;
  assign o_acc        = out_q;
  assign o_acc_rdy    = out_rdy_q;

  // Lane mask for the incoming command: a run of lane bits placed in the mode's slice.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane_max = DWd;
    lane_eff = DWd;
    run_w    = 0;
    run_off  = 0;
    case (i_cfg_mode)
      MODE_M2: lane_max = DWd / 2;
      MODE_M4: lane_max = DWd / 4;
      default: lane_max = DWd;
    endcase
    if (i_cfg_lanes == 5'd0 || int'(i_cfg_lanes) > lane_max) lane_eff = lane_max;
    else                                                      lane_eff = int'(i_cfg_lanes);
    case (i_cfg_mode)
      MODE_M2: begin run_w = 2 * lane_eff; run_off = DWd;     end
      MODE_M4: begin run_w = 4 * lane_eff; run_off = 2 * DWd; end
      default: begin run_w = lane_eff;     run_off = 0;       end
    endcase
    mask_d = (~({(3*DWd){1'b1}} << run_w)) << run_off;
  end

  // Accumulator update for the beat on offer: wrap, or sticky saturation when enabled.
  always_comb begin
`ifdef AU_SCHED_SAT_EN
    sum_wide = {acc_q[AccWd-1], acc_q} + {sum_ext[AccWd-1], sum_ext};
    sat_hit  = 1'b0;
    if (sat_q) begin
      acc_next = acc_q;
    end else if (sum_wide[AccWd] != sum_wide[AccWd-1]) begin
      acc_next = sum_wide[AccWd] ? ACC_MIN : ACC_MAX;
      sat_hit  = 1'b1;
    end else begin
      acc_next = sum_wide[AccWd-1:0];
    end
`else
    acc_next = acc_q + sum_ext;
`endif
  end

  // FSM next-state: IDLE -> CLR -> RUN -> DRAIN -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_cfg_valid) state_d = S_CLR;
      S_CLR:   state_d = S_RUN;
      S_RUN:   if (beat_fire && last_beat && (grp_q == nout_q)) state_d = S_DRAIN;
      S_DRAIN: if (!out_rdy_q || i_acc_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command latch, unit control copies and lane mask.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q  <= 2'd0;
      inumt_q <= 1'b0;
      wnumt_q <= 1'b0;
      len_q   <= '0;
      nout_q  <= '0;
      mask_q  <= '0;
    end else if (cmd_accept) begin
      mode_q  <= i_cfg_mode;
      inumt_q <= i_cfg_inumt;
      wnumt_q <= i_cfg_wnumt;
      len_q   <= i_cfg_len;
      nout_q  <= i_cfg_nout;
      mask_q  <= mask_d;
    end else if (state_q == S_DRAIN && state_d == S_IDLE) begin
      mask_q  <= '0;
    end
  end

  // Beat/group counters and running accumulator.
  always_ff @(posedge i_clk) begin
    if (i_rst || cmd_accept) begin
      beat_q <= '0;
      grp_q  <= '0;
      acc_q  <= '0;
`ifdef AU_SCHED_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else if (beat_fire) begin
      if (last_beat) begin
        beat_q <= '0;
        grp_q  <= grp_q + 1'b1;
        acc_q  <= '0;
`ifdef AU_SCHED_SAT_EN
        sat_q  <= 1'b0;
`endif
      end else begin
        beat_q <= beat_q + 1'b1;
        acc_q  <= acc_next;
`ifdef AU_SCHED_SAT_EN
        sat_q  <= sat_q | sat_hit;
`endif
      end
    end
  end

  // Result register: a reload in the same cycle as an ack keeps rdy high with the new value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q     <= '0;
      out_rdy_q <= 1'b0;
    end else if (beat_fire && last_beat) begin
      out_q     <= acc_next;
      out_rdy_q <= 1'b1;
    end else if (i_acc_ack) begin
      out_rdy_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_au_sched.sv
// tb_au_sched: directed self-checking bench for au_sched.
// A second instance with a 12-bit accumulator covers the wrap/saturate corner.
module tb_au_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [1:0]  cfg_mode;
  logic        cfg_inumt, cfg_wnumt;
  logic [4:0]  cfg_lanes;
  logic [7:0]  cfg_len, cfg_nout;
  logic [10:0] au_sum;
  logic        au_sum_rdy;
  logic        acc_ack;

  logic        cfg_ready, au_inumt, au_wnumt, au_reset, au_stall, au_sum_ack, acc_rdy, busy;
  logic [47:0] au_mask;
  logic [1:0]  au_mode;
  logic [19:0] acc;

  logic        s_cfg_ready, s_au_inumt, s_au_wnumt, s_au_reset, s_au_stall, s_au_sum_ack;
  logic        s_acc_rdy, s_busy;
  logic [47:0] s_au_mask;
  logic [1:0]  s_au_mode;
  logic [11:0] s_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  au_sched dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_mode(cfg_mode), .i_cfg_inumt(cfg_inumt), .i_cfg_wnumt(cfg_wnumt),
    .i_cfg_lanes(cfg_lanes), .i_cfg_len(cfg_len), .i_cfg_nout(cfg_nout),
    .o_au_mask(au_mask), .o_au_mode(au_mode), .o_au_inumt(au_inumt), .o_au_wnumt(au_wnumt),
    .o_au_reset(au_reset), .o_au_stall(au_stall), .i_au_sum(au_sum),
    .i_au_sum_rdy(au_sum_rdy), .o_au_sum_ack(au_sum_ack), .o_acc(acc),
    .o_acc_rdy(acc_rdy), .i_acc_ack(acc_ack), .o_busy(busy)
  );

  au_sched #(.AccWd(12)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(s_cfg_ready),
    .i_cfg_mode(cfg_mode), .i_cfg_inumt(cfg_inumt), .i_cfg_wnumt(cfg_wnumt),
    .i_cfg_lanes(cfg_lanes), .i_cfg_len(cfg_len), .i_cfg_nout(cfg_nout),
    .o_au_mask(s_au_mask), .o_au_mode(s_au_mode), .o_au_inumt(s_au_inumt),
    .o_au_wnumt(s_au_wnumt), .o_au_reset(s_au_reset), .o_au_stall(s_au_stall),
    .i_au_sum(au_sum), .i_au_sum_rdy(au_sum_rdy), .o_au_sum_ack(s_au_sum_ack),
    .o_acc(s_acc), .o_acc_rdy(s_acc_rdy), .i_acc_ack(acc_ack), .o_busy(s_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; returns in CLR.
  task automatic send_cmd(input logic [1:0] m, input logic sg, input logic [4:0] ln,
                          input logic [7:0] len, input logic [7:0] nout);
    cfg_valid = 1'b1; cfg_mode = m; cfg_inumt = sg; cfg_wnumt = sg;
    cfg_lanes = ln; cfg_len = len; cfg_nout = nout;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Offer one partial sum and wait (bounded) until it is taken.
  task automatic beat(input logic [10:0] s);
    int n;
    au_sum = s; au_sum_rdy = 1'b1;
    #1;
    n = 0;
    while (!au_sum_ack && n < 20) begin tick(); n++; end
    if (n >= 20) check("beat_timeout", 64'(n), 64'd0);
    tick();
    au_sum_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_inumt = 1'b0; cfg_wnumt = 1'b0;
    cfg_lanes = 5'd0; cfg_len = 8'd0; cfg_nout = 8'd0; au_sum = '0; au_sum_rdy = 1'b0;
    acc_ack = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_au_reset", au_reset, 1'b1);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_mask", au_mask, 48'h0);
    check("rst_stall_ack", {au_stall, au_sum_ack}, 2'b00);
    check("rst_acc", {acc_rdy, acc}, 21'h0);
    rst = 1'b0;
    tick();
    check("idle_au_reset", au_reset, 1'b0);

    // M4, 4 lanes, signed, len=3, one result: 100-20+5+7 = 92
    send_cmd(2'd3, 1'b1, 5'd4, 8'd3, 8'd0);
    check("m4_clr_reset", {au_reset, au_stall}, 2'b10);
    check("m4_mask", au_mask, 48'hFFFF_0000_0000);
    check("m4_mode_types", {au_mode, au_inumt, au_wnumt}, 4'b1111);
    check("m4_busy", {busy, cfg_ready}, 2'b10);
    tick();
    check("m4_run", {au_reset, au_stall, au_sum_ack}, 3'b011);
    beat(11'd100); beat(-11'sd20); beat(11'd5);
    check("m4_no_early_rdy", acc_rdy, 1'b0);
    beat(11'd7);
    check("m4_result", {acc_rdy, acc}, {1'b1, 20'd92});
    check("m4_drain", {busy, au_stall, au_sum_ack}, 3'b100);
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
    check("m4_idle", {cfg_ready, acc_rdy}, 2'b10);
    check("m4_idle_mask", au_mask, 48'h0);

    // M2, 3 lanes, len=0, three results with consumer stalled after the first
    send_cmd(2'd2, 1'b1, 5'd3, 8'd0, 8'd2);
    check("m2_mask", au_mask, 48'h0000_003F_0000);
    tick();
    beat(11'd9);
    check("m2_r0", {acc_rdy, acc}, {1'b1, 20'd9});
    check("m2_blocked", {au_stall, au_sum_ack}, 2'b00);
    au_sum = -11'sd6; au_sum_rdy = 1'b1;
    tick(); tick();
    check("m2_held", {acc_rdy, acc, au_sum_ack}, {1'b1, 20'd9, 1'b0});
    acc_ack = 1'b1;
    #1;
    check("m2_unblocked", {au_stall, au_sum_ack}, 2'b11);
    tick();
    check("m2_r1_reload_ack", {acc_rdy, acc}, {1'b1, 20'(-6)});
    au_sum = 11'd1;
    tick();
    au_sum_rdy = 1'b0;
    check("m2_r2", {acc_rdy, acc}, {1'b1, 20'd1});
    check("m2_drain", {busy, au_stall}, 2'b10);
    tick();
    acc_ack = 1'b0;
    check("m2_idle", {cfg_ready, acc_rdy}, 2'b10);

    // XNOR, lanes=0 (max), unsigned, len=1, two results; reload while previous result pending
    send_cmd(2'd0, 1'b0, 5'd0, 8'd1, 8'd1);
    check("xnor_mask", au_mask, 48'h0000_0000_FFFF);
    check("xnor_types", {au_mode, au_inumt, au_wnumt}, 4'b0000);
    tick();
    cfg_valid = 1'b1; cfg_mode = 2'd3;
    tick();
    cfg_valid = 1'b0;
    check("xnor_cfg_ignored", {au_mode, au_reset, cfg_ready}, 4'b0000);
    beat(11'd3); beat(11'd4);
    check("xnor_r0", {acc_rdy, acc}, {1'b1, 20'd7});
    beat(11'd10);
    au_sum = -11'sd2; au_sum_rdy = 1'b1;
    #1;
    check("xnor_blocked", au_sum_ack, 1'b0);
    acc_ack = 1'b1;
    tick();
    au_sum_rdy = 1'b0;
    check("xnor_r1_back2back", {acc_rdy, acc}, {1'b1, 20'd8});
    tick();
    acc_ack = 1'b0;
    check("xnor_idle", {cfg_ready, acc_rdy, au_mask}, {2'b10, 48'h0});

    // Reset in the middle of RUN with beat=2
    send_cmd(2'd1, 1'b1, 5'd5, 8'd5, 8'd0);
    check("m1_mask", au_mask, 48'h0000_0000_001F);
    tick();
    beat(11'd50); beat(11'd60);
    rst = 1'b1;
    #1;
    check("mid_rst_au_reset", au_reset, 1'b1);
    tick();
    check("mid_rst_state", {cfg_ready, busy, acc_rdy}, 3'b100);
    check("mid_rst_ctrl", {au_mask, au_mode}, 50'h0);
    rst = 1'b0;
    tick();

    // 256 beats of +900: full-width sum 230400; 12-bit instance wraps or saturates
    send_cmd(2'd1, 1'b1, 5'd16, 8'd255, 8'd0);
    tick();
    au_sum = 11'd900; au_sum_rdy = 1'b1;
    for (int i = 0; i < 256; i++) tick();
    au_sum_rdy = 1'b0;
    check("long_wide", {acc_rdy, acc}, {1'b1, 20'd230400});
`ifdef AU_SCHED_SAT_EN
    check("long_12b", {s_acc_rdy, s_acc}, {1'b1, 12'd2047});
`else
    check("long_12b", {s_acc_rdy, s_acc}, {1'b1, 12'(900 * 256)});
`endif
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
    check("long_idle", {cfg_ready, s_cfg_ready, acc_rdy, s_acc_rdy}, 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
